// File: rtl/light_pkg.sv
// light_pkg: phase, lamp-pattern and fault-code definitions shared by the lamp bus controller and monitor
package light_pkg;

  typedef enum logic [2:0] {
    PH_ALLRED  = 3'd0,
    PH_R1G2    = 3'd1,
    PH_R1Y2    = 3'd2,
    PH_G1R2    = 3'd3,
    PH_Y1R2    = 3'd4,
    PH_ILLEGAL = 3'd7
  } phase_t;

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_COMBO = 2'd1,
    FC_TRANS = 2'd2,
    FC_DWELL = 2'd3
  } fault_t;

  // Lamp vectors in {R1,R2,Y1,Y2,G1,G2} order
  localparam logic [5:0] LAMP_ALLRED = 6'b110000;
  localparam logic [5:0] LAMP_R1G2   = 6'b100001;
  localparam logic [5:0] LAMP_R1Y2   = 6'b100100;
  localparam logic [5:0] LAMP_G1R2   = 6'b010010;
  localparam logic [5:0] LAMP_Y1R2   = 6'b011000;

  function automatic phase_t decode(input logic [5:0] l);
    return l == LAMP_ALLRED ? PH_ALLRED :
           l == LAMP_R1G2   ? PH_R1G2   :
           l == LAMP_R1Y2   ? PH_R1Y2   :
           l == LAMP_G1R2   ? PH_G1R2   :
           l == LAMP_Y1R2   ? PH_Y1R2   : PH_ILLEGAL;
  endfunction

  // ALLRED is always reachable: it is the controller's abort path
  function automatic logic legal_next(input phase_t p, input phase_t n);
    return n == PH_ALLRED ||
           (n == PH_R1G2 && (p == PH_ALLRED || p == PH_Y1R2)) ||
           (n == PH_R1Y2 && p == PH_R1G2) ||
           (n == PH_G1R2 && p == PH_R1Y2) ||
           (n == PH_Y1R2 && p == PH_G1R2);
  endfunction

endpackage

// File: rtl/sec_timer.sv
// sec_timer: cycle divider plus saturating seconds counter measuring time spent in one phase
module sec_timer #(
  parameter int CLK_PER_SEC = 1000,
  localparam int DW = CLK_PER_SEC > 1 ? $clog2(CLK_PER_SEC) : 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_restart,
  input  logic       i_hold,
  input  logic [7:0] i_exp,
  output logic       o_wrap,
  output logic [7:0] o_sec,
  output logic       o_over
);

  logic [DW-1:0] r_div;
  logic [7:0]    r_sec;

  assign o_wrap = r_div == DW'(CLK_PER_SEC - 1);
  assign o_sec  = r_sec;
  // Counter value equals elapsed-1, so this fires on cycle i_exp*CLK_PER_SEC+1 after entry
  assign o_over = r_sec == i_exp && r_div == '0;

  // Divider and seconds count; seconds saturate so a stuck phase never wraps back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_sec <= '0;
    end else if (i_restart || i_hold) begin
      r_div <= '0;
      r_sec <= '0;
    end else if (o_wrap) begin
      r_div <= '0;
      r_sec <= r_sec + {7'd0, r_sec != 8'hff};
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/light_monitor.sv
// light_monitor: decodes the lamp bus, drives the seconds countdown and latches the first protocol fault
module light_monitor import light_pkg::*; #(
  parameter int CLK_PER_SEC = 1000,
  parameter int GREEN_SEC   = 55,
  parameter int YELLOW_SEC  = 5
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       R1,
  input  logic       R2,
  input  logic       Y1,
  input  logic       Y2,
  input  logic       G1,
  input  logic       G2,
  output logic [2:0] phase,
  output logic [7:0] remain,
  output logic       fault,
  output logic [1:0] fault_code
);

  logic [5:0] r_lamp;
  phase_t     r_prev;
  logic       r_en;
  logic       r_fault;
  fault_t     r_code;

  phase_t     w_phase;
  fault_t     w_code;
  logic       w_chg, w_start, w_short, w_ill, w_trans, w_dwell;
  logic       w_wrap, w_over;
  logic [7:0] w_sec, w_exp_cur, w_exp_prev;

  function automatic logic [7:0] dwell(input phase_t p);
    return (p == PH_R1G2 || p == PH_G1R2) ? 8'(GREEN_SEC) :
           (p == PH_R1Y2 || p == PH_Y1R2) ? 8'(YELLOW_SEC) : 8'd0;
  endfunction

  sec_timer #(.CLK_PER_SEC(CLK_PER_SEC)) u_timer (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .i_restart (w_start),
    .i_hold    (!en),
    .i_exp     (w_exp_cur),
    .o_wrap    (w_wrap),
    .o_sec     (w_sec),
    .o_over    (w_over)
  );

  // Phase decode, successor/dwell checks and countdown; timer values are stale on a change cycle
  always_comb begin
    w_phase    = decode(r_lamp);
    w_chg      = w_phase != r_prev;
    w_start    = w_chg || (en && !r_en);
    w_exp_cur  = dwell(w_phase);
    w_exp_prev = dwell(r_prev);
    w_short    = w_chg && w_exp_prev != 8'd0 && w_phase != PH_ALLRED &&
                 !(w_wrap && w_sec == w_exp_prev - 8'd1);
    w_ill      = en && w_phase == PH_ILLEGAL;
    w_trans    = en && w_chg && !legal_next(r_prev, w_phase);
    w_dwell    = en && r_en && (w_short || (!w_chg && w_exp_cur != 8'd0 && w_over));
    w_code     = w_ill ? FC_COMBO : w_trans ? FC_TRANS : w_dwell ? FC_DWELL : FC_NONE;
    remain     = (!en || w_exp_cur == 8'd0) ? 8'd0 :
                 w_start ? w_exp_cur :
                 w_sec < w_exp_cur ? w_exp_cur - w_sec : 8'd1;
  end

  // Lamp input register and the phase/enable history used for change detection
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_lamp <= LAMP_ALLRED;
      r_prev <= PH_ALLRED;
      r_en   <= 1'b0;
    end else begin
      r_lamp <= {R1, R2, Y1, Y2, G1, G2};
      r_prev <= w_phase;
      r_en   <= en;
    end
  end

  // Sticky first-fault latch; a fault arriving together with clr replaces the old one
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_fault <= 1'b0;
      r_code  <= FC_NONE;
    end else if (w_code != FC_NONE && (!r_fault || clr)) begin
      r_fault <= 1'b1;
      r_code  <= w_code;
    end else if (clr) begin
      r_fault <= 1'b0;
      r_code  <= FC_NONE;
    end
  end

  assign phase      = w_phase;
  assign fault      = r_fault;
  assign fault_code = r_code;

endmodule
